// File: rtl/twoaddsub_pkg.sv
// Shared constants for the two's-complement add/subtract unit.
package twoaddsub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/twoaddsub_full_adder.sv
// One-bit full adder cell; the ripple chain in twoaddsub is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/twoaddsub.sv
// Registered ripple-carry add/subtract with signed overflow flag.
// Define TWOADDSUB_COUT_EN to expose the raw MSB carry-out as port cout.
module twoaddsub
  import twoaddsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             out_valid
`ifdef TWOADDSUB_COUT_EN
  ,
  output logic             cout
`endif
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] s_c;
  logic [WIDTH:0]   carry;
  logic             ovf_c;

  // Subtraction is a + ~b + 1: invert B and inject m as the carry-in.
  assign b_x      = b ^ {WIDTH{m}};
  assign carry[0] = m;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_x[i]),
      .cin  (carry[i]),
      .s    (s_c[i]),
      .cout (carry[i+1])
    );
  end

  assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];

  // Result registers hold across idle cycles; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
`ifdef TWOADDSUB_COUT_EN
      cout      <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= s_c;
        ovf <= ovf_c;
`ifdef TWOADDSUB_COUT_EN
        cout <= carry[WIDTH];
`endif
      end
    end
  end

endmodule

// File: tb/tb_twoaddsub.sv
// Directed plus random bench for twoaddsub with an expected-result queue.
module tb_twoaddsub;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
    logic         cout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         m;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         ovf;
  logic         out_valid;
`ifdef TWOADDSUB_COUT_EN
  logic         cout;
`endif

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_q[$];
  exp_t hold;

  always #5 clk = ~clk;

  twoaddsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .m         (m),
    .in_valid  (in_valid),
    .sum       (sum),
    .ovf       (ovf),
    .out_valid (out_valid)
`ifdef TWOADDSUB_COUT_EN
    ,
    .cout      (cout)
`endif
  );

  // Reference arithmetic done on integers, independent of the carry chain.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic md);
    exp_t e;
    int sx;
    int sy;
    int r;
    sx = $signed(x);
    sy = $signed(y);
    r  = md ? (sx - sy) : (sx + sy);
    e.sum  = W'(r);
    e.ovf  = (r > 127) || (r < -128);
    e.cout = md ? (x >= y) : ((int'(x) + int'(y)) > 255);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic v);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sum"}, 32'(sum), 32'(e.sum));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`ifdef TWOADDSUB_COUT_EN
    chk({tag, ".cout"}, 32'(cout), 32'(e.cout));
`endif
  endtask

  // Drive one cycle of stimulus, then check the outputs just after the edge.
  task automatic cyc(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tm, input logic tv, input logic tr);
    exp_t e;
    rst      = tr;
    a        = ta;
    b        = tb;
    m        = tm;
    in_valid = tv;
    if (tv && !tr) sb_q.push_back(model(ta, tb, tm));
    @(posedge clk);
    #1;
    if (tr) begin
      hold = '0;
      check_out(tag, hold, 1'b0);
    end else if (tv) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".queue_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        hold = e;
        check_out(tag, e, 1'b1);
      end
    end else begin
      check_out(tag, hold, 1'b0);
    end
  endtask

  initial begin
    hold     = '0;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    m        = 1'b0;
    in_valid = 1'b0;

    cyc("reset0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc("reset1", 8'h12, 8'h34, 1'b0, 1'b1, 1'b1);

    // Directed vectors, back-to-back.
    cyc("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc("add_01_ff", 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc("add_55_aa", 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0);
    cyc("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    cyc("sub_6c_ca", 8'h6C, 8'hCA, 1'b1, 1'b1, 1'b0);

    // Idle cycles: outputs hold, inputs change underneath.
    cyc("hold0", 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc("hold1", 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);

    cyc("sub_00_80", 8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
    cyc("sub_00_00", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc("add_80_80", 8'h80, 8'h80, 1'b0, 1'b1, 1'b0);

    // Reset overrides a simultaneous valid operation.
    cyc("rst_valid", 8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    cyc("post_rst_idle", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc("post_rst_first", 8'h40, 8'h40, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      cyc("rand", W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    cyc("final_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    chk("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
